// File: rtl/goose_pkg.sv
// Goose Run shared types: FSM states, LFSR taps, BCD widths.
// No ports; imported by the core, its interface users and the score counter.
package goose_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam int LANE_W_DEF = 8;
  localparam int BCD_W      = 4;
  localparam int BCD_DIGITS = 4;

  // x^8+x^6+x^5+x^4+1 -> state bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(
    input logic [7:0] s
  );
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/goose_game_core_if.sv
// Goose Run game bus: step/button inputs and display outputs.
// master drives tick/jump_btn/start_btn; slave (core) drives the rest.
interface goose_game_core_if #(
  parameter int LANE_W = 8
);

  logic              tick;
  logic              jump_btn;
  logic              start_btn;
  logic [LANE_W-1:0] lane;
  logic              goose_air;
  logic [15:0]       score;
  logic              running;
  logic              game_over;

  modport master (
    output tick, jump_btn, start_btn,
    input  lane, goose_air, score,
    input  running, game_over
  );

  modport slave (
    input  tick, jump_btn, start_btn,
    output lane, goose_air, score,
    output running, game_over
  );

endinterface

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter, saturating at 9999.
// Ports: clk, clr_n (sync clear), inc, load/load_val (preload), q.
module bcd_counter4
  import goose_pkg::*;
(
  input  logic        clk,
  input  logic        clr_n,
  input  logic        inc,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);

  localparam logic [15:0] MAX = 16'h9999;

  logic [15:0]      cnt_q, cnt_d;
  logic             carry;
  logic [BCD_W-1:0] dig;

  always_comb begin
    cnt_d = cnt_q;
    carry = 1'b1;
    dig   = '0;
    if (load) begin
      cnt_d = load_val;
    end else if (inc && cnt_q != MAX) begin
      for (int i = 0; i < BCD_DIGITS; i++) begin
        dig = cnt_q[i*BCD_W +: BCD_W];
        if (carry) begin
          if (dig == 4'd9) begin
            cnt_d[i*BCD_W +: BCD_W] = '0;
          end else begin
            cnt_d[i*BCD_W +: BCD_W] = dig + 1'b1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/goose_game_core.sv
// Goose Run step engine: one game step per tick (scroll, jump, hit, score).
// Ports: clock, reset_n (sync, active low), gif (slave side of game bus).
module goose_game_core
  import goose_pkg::*;
#(
  parameter int         LANE_W        = LANE_W_DEF,
  parameter int         JUMP_TICKS    = 2,
  parameter int         SPAWN_GAP_MIN = 2,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input logic               clock,
  input logic               reset_n,
  goose_game_core_if.slave  gif
);

  localparam int AW = $clog2(JUMP_TICKS + 1);
  localparam int GW = $clog2(SPAWN_GAP_MIN + 1);
  localparam logic [AW-1:0] JT = AW'(JUMP_TICKS);
  localparam logic [GW-1:0] GM = GW'(SPAWN_GAP_MIN);
  // an all-zero LFSR would lock up
  localparam logic [7:0] SEED =
    (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  state_e            state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [AW-1:0]     air_q, air_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              jreq_q, jreq_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic              gair_q, gair_d;
  logic              run_q, run_d;
  logic              over_q, over_d;
  logic              jump_q, start_q;

  logic jump_rise, start_rise;
  logic spawn, collide;
  logic score_inc, clr_game, score_clr_n;

  assign jump_rise  = gif.jump_btn & ~jump_q;
  assign start_rise = gif.start_btn & ~start_q;

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    air_d     = air_q;
    gap_d     = gap_q;
    jreq_d    = jreq_q;
    lfsr_d    = lfsr_q;
    gair_d    = gair_q;
    spawn     = 1'b0;
    collide   = 1'b0;
    score_inc = 1'b0;
    clr_game  = 1'b0;
    unique case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          state_d  = RUN;
          lane_d   = '0;
          air_d    = '0;
          gap_d    = '0;
          jreq_d   = 1'b0;
          gair_d   = 1'b0;
          clr_game = 1'b1;
        end
      end
      RUN: begin
        if (gif.tick) begin
          if (jreq_q && air_q == '0) begin
            air_d  = JT;
            jreq_d = 1'b0;
          end else if (air_q != '0) begin
            air_d = air_q - 1'b1;
          end
          spawn = lfsr_q[0] && (gap_q >= GM);
          if (spawn)           gap_d = '0;
          else if (gap_q < GM) gap_d = gap_q + 1'b1;
          lane_d  = {spawn, lane_q[LANE_W-1:1]};
          lfsr_d  = lfsr_next(lfsr_q);
          gair_d  = (air_d != '0);
          collide = lane_d[0] && (air_d == '0);
          if (collide) state_d   = OVER;
          else         score_inc = lane_q[0];
        end
        // a rise on a tick cycle is kept for the next tick
        if (jump_rise) jreq_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    run_d  = (state_d == RUN);
    over_d = (state_d == OVER);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lane_q  <= '0;
      air_q   <= '0;
      gap_q   <= '0;
      jreq_q  <= 1'b0;
      lfsr_q  <= SEED;
      gair_q  <= 1'b0;
      run_q   <= 1'b0;
      over_q  <= 1'b0;
      jump_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      air_q   <= air_d;
      gap_q   <= gap_d;
      jreq_q  <= jreq_d;
      lfsr_q  <= lfsr_d;
      gair_q  <= gair_d;
      run_q   <= run_d;
      over_q  <= over_d;
      jump_q  <= gif.jump_btn;
      start_q <= gif.start_btn;
    end
  end

  assign score_clr_n = reset_n & ~clr_game;

  bcd_counter4 u_score (
    .clk      (clock),
    .clr_n    (score_clr_n),
    .inc      (score_inc),
    .load     (1'b0),
    .load_val (16'h0000),
    .q        (gif.score)
  );

  assign gif.lane      = lane_q;
  assign gif.goose_air = gair_q;
  assign gif.running   = run_q;
  assign gif.game_over = over_q;

endmodule
